// File: rtl/axis_pulse_sequencer.sv
// axis_pulse_sequencer: streams a BRAM table of 64-bit pulse words to an AXI4-Stream
// sink, repeating the whole table a configured number of times per trigger.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   cfg_data                 {repeats, last_addr}, sampled when a trigger is accepted
//   trg_flag                 start request (ignored while busy or when repeats == 0)
//   abort_flag               stop request, only with AXIS_PULSE_SEQUENCER_ABORT_EN defined
//   busy, sts_data           run status and completed table passes
//   bram_porta_*             BRAM read port (1-cycle read latency)
//   m_axis_*                 pulse word stream, tlast on the final word of the final pass
//
// Optional feature macro: AXIS_PULSE_SEQUENCER_ABORT_EN adds abort_flag.
module axis_pulse_sequencer #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int CNTR_WIDTH      = 32
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [BRAM_ADDR_WIDTH+CNTR_WIDTH-1:0] cfg_data,
    input  logic                                  trg_flag,
`ifdef AXIS_PULSE_SEQUENCER_ABORT_EN
    input  logic                                  abort_flag,
`endif
    output logic                                  busy,
    output logic [CNTR_WIDTH-1:0]                 sts_data,
    output logic                                  bram_porta_clk,
    output logic                                  bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]            bram_porta_addr,
    input  logic [63:0]                           bram_porta_rddata,
    input  logic                                  m_axis_tready,
    output logic [63:0]                           m_axis_tdata,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
    logic [CNTR_WIDTH-1:0]      rpt_q, rpt_d, sts_q, sts_d;
    logic [63:0]                word_q, word_d;
    logic                       valid_q, valid_d, tlast_q, tlast_d, busy_q, busy_d;
    logic                       abort_q, abort_d, abort_in, stop, end_pass, done;
    logic [BRAM_ADDR_WIDTH-1:0] cfg_last;
    logic [CNTR_WIDTH-1:0]      cfg_rpt;

`ifdef AXIS_PULSE_SEQUENCER_ABORT_EN
    assign abort_in = abort_flag;
`else
    assign abort_in = 1'b0;
`endif

    assign cfg_last = cfg_data[BRAM_ADDR_WIDTH-1:0];
    assign cfg_rpt  = cfg_data[BRAM_ADDR_WIDTH+CNTR_WIDTH-1:BRAM_ADDR_WIDTH];

    // An abort seen during SEND is remembered until the word handshakes.
    assign stop     = abort_q | abort_in;
    assign end_pass = addr_q == last_addr_q;
    assign done     = (end_pass && rpt_q == CNTR_WIDTH'(1)) || stop;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        rpt_d       = rpt_q;
        sts_d       = sts_q;
        word_d      = word_q;
        valid_d     = valid_q;
        tlast_d     = tlast_q;
        busy_d      = busy_q;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trg_flag && cfg_rpt != '0) begin
                    last_addr_d = cfg_last;
                    rpt_d       = cfg_rpt;
                    addr_d      = '0;
                    sts_d       = '0;
                    busy_d      = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                state_d = abort_in ? IDLE : LOAD;
                busy_d  = !abort_in;
                addr_d  = abort_in ? '0 : addr_q;
            end
            LOAD: begin
                if (abort_in) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    addr_d  = '0;
                end else begin
                    word_d  = bram_porta_rddata;
                    valid_d = 1'b1;
                    tlast_d = end_pass && rpt_q == CNTR_WIDTH'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                abort_d = stop;
                if (m_axis_tready) begin
                    abort_d = 1'b0;
                    valid_d = 1'b0;
                    tlast_d = 1'b0;
                    sts_d   = end_pass ? sts_q + 1'b1 : sts_q;
                    rpt_d   = end_pass ? rpt_q - 1'b1 : rpt_q;
                    addr_d  = (end_pass || done) ? '0 : addr_q + 1'b1;
                    state_d = done ? IDLE : FETCH;
                    busy_d  = !done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rpt_q       <= '0;
            sts_q       <= '0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rpt_q       <= rpt_d;
            sts_q       <= sts_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            abort_q     <= abort_d;
        end
    end

    assign busy            = busy_q;
    assign sts_data        = sts_q;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_q;
    assign m_axis_tdata    = word_q;
    assign m_axis_tvalid   = valid_q;
    assign m_axis_tlast    = tlast_q;
endmodule

// File: tb/tb_axis_pulse_sequencer.sv
// tb_axis_pulse_sequencer: randomized scoreboard bench for axis_pulse_sequencer.
module tb_axis_pulse_sequencer;
    localparam int AW = 4;
    localparam int CW = 8;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [AW+CW-1:0]  cfg_data = '0;
    logic              trg_flag = 1'b0;
`ifdef AXIS_PULSE_SEQUENCER_ABORT_EN
    logic              abort_flag = 1'b0;
`endif
    logic              busy;
    logic [CW-1:0]     sts_data;
    logic              bram_porta_clk, bram_porta_rst;
    logic [AW-1:0]     bram_porta_addr;
    logic [63:0]       bram_porta_rddata = '0;
    logic              m_axis_tready = 1'b0;
    logic [63:0]       m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast;

    int   checks = 0, errors = 0, hs_count = 0, tlast_seen = 0;
    bit   rnd_rdy = 1'b0;
    exp_t exp_q[$];
    logic [63:0] mem [2**AW];

    axis_pulse_sequencer #(.BRAM_ADDR_WIDTH(AW), .CNTR_WIDTH(CW)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .trg_flag(trg_flag),
`ifdef AXIS_PULSE_SEQUENCER_ABORT_EN
        .abort_flag(abort_flag),
`endif
        .busy(busy), .sts_data(sts_data), .bram_porta_clk(bram_porta_clk),
        .bram_porta_rst(bram_porta_rst), .bram_porta_addr(bram_porta_addr),
        .bram_porta_rddata(bram_porta_rddata), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    // Synchronous-read BRAM: data for an address appears one cycle later.
    always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

    initial begin
        forever begin
            @(posedge aclk);
            #2;
            if (rnd_rdy) m_axis_tready = $urandom_range(0, 3) != 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks that a
    // stalled word stays put until it is accepted.
    initial begin
        logic        pv, pl;
        logic [63:0] pd;
        exp_t        e;
        pv = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) pv = 1'b0;
            else begin
                if (pv) begin
                    check("hold_valid", m_axis_tvalid, 1);
                    check("hold_data", m_axis_tdata, pd);
                    check("hold_last", m_axis_tlast, pl);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    hs_count++;
                    if (m_axis_tlast) tlast_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected no word", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", m_axis_tdata, e.data);
                        check("word_last", m_axis_tlast, e.last);
                    end
                    pv = 1'b0;
                end else begin
                    pv = m_axis_tvalid;
                    pd = m_axis_tdata;
                    pl = m_axis_tlast;
                end
            end
        end
    end

    // Reference: every pass emits entries 0..la in order; only the very last word carries tlast.
    task automatic model(input int la, input int rp);
        for (int p = 1; p <= rp; p++)
            for (int a = 0; a <= la; a++)
                exp_q.push_back(exp_t'{mem[a], p == rp && a == la});
    endtask

    task automatic fill_table();
        for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic trigger(input int la, input int rp);
        cfg_data = {rp[CW-1:0], la[AW-1:0]};
        trg_flag = 1'b1;
        cycles(1);
        trg_flag = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!m_axis_tvalid && n < 100) begin
            cycles(1);
            n++;
        end
        check({name, "_valid_seen"}, m_axis_tvalid, 1);
    endtask

    task automatic wait_idle(input string name, input int sts);
        int n = 0;
        while (busy && n < 5000) begin
            cycles(1);
            n++;
        end
        check({name, "_busy_done"}, busy, 0);
        check({name, "_sts"}, sts_data, sts);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic run(input string name, input int la, input int rp);
        tlast_seen = 0;
        model(la, rp);
        trigger(la, rp);
        wait_idle(name, rp);
        check({name, "_tlast_count"}, tlast_seen, 1);
    endtask

    initial begin
        fill_table();
        m_axis_tready = 1'b1;
        cycles(3);
        check("reset_busy", busy, 0);
        check("reset_sts", sts_data, 0);
        check("reset_addr", bram_porta_addr, 0);
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_tlast", m_axis_tlast, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_bram_rst", bram_porta_rst, 1);
        aresetn = 1'b1;
        cycles(1);
        check("bram_rst_released", bram_porta_rst, 0);
        check("bram_clk", bram_porta_clk, aclk);

        mem[0] = 64'h00000005_0000_1234;
        mem[1] = 64'h00000003_0000_ABCD;
        tlast_seen = 0;
        model(1, 1);
        trigger(1, 1);
        check("lat_busy", busy, 1);
        check("lat_valid_fetch", m_axis_tvalid, 0);
        cycles(1);
        check("lat_valid_load", m_axis_tvalid, 0);
        cycles(1);
        check("lat_valid_send", m_axis_tvalid, 1);
        wait_idle("basic", 1);
        check("basic_tlast_count", tlast_seen, 1);

        fill_table();
        rnd_rdy = 1'b1;
        run("repeats", 2, 3);

        rnd_rdy = 1'b0;
        #2;
        m_axis_tready = 1'b0;
        tlast_seen = 0;
        model(3, 2);
        trigger(3, 2);
        wait_valid("bp");
        cycles(10);
        rnd_rdy = 1'b1;
        wait_idle("bp", 2);
        check("bp_tlast_count", tlast_seen, 1);

        trigger(2, 0);
        check("zero_busy", busy, 0);
        cycles(4);
        check("zero_busy_later", busy, 0);
        check("zero_tvalid", m_axis_tvalid, 0);

        fill_table();
        tlast_seen = 0;
        model(4, 2);
        trigger(4, 2);
        cycles(5);
        trigger(7, 5);
        wait_idle("ignored", 2);
        check("ignored_tlast_count", tlast_seen, 1);

        fill_table();
        run("full_table", 2**AW - 1, 2);
        run("single_entry", 0, 3);
        run("max_repeats", 0, 2**CW - 1);
        for (int i = 0; i < 3; i++) begin
            fill_table();
            run("random", $urandom_range(0, 2**AW - 1), $urandom_range(1, 4));
        end

        rnd_rdy = 1'b0;
        #2;
        m_axis_tready = 1'b0;
        trigger(3, 2);
        wait_valid("rst");
        aresetn = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        exp_q.delete();
        cycles(2);
        aresetn = 1'b1;
        cycles(1);
        check("rst_addr", bram_porta_addr, 0);
        m_axis_tready = 1'b1;
        run("rst_restart", 3, 1);

`ifdef AXIS_PULSE_SEQUENCER_ABORT_EN
        begin
            int n = 0;
            fill_table();
            tlast_seen = 0;
            hs_count = 0;
            for (int a = 0; a <= 3; a++) exp_q.push_back(exp_t'{mem[a], 1'b0});
            exp_q.push_back(exp_t'{mem[0], 1'b0});
            trigger(3, 4);
            while (hs_count < 4 && n < 200) begin
                cycles(1);
                n++;
            end
            m_axis_tready = 1'b0;
            wait_valid("abort");
            abort_flag = 1'b1;
            cycles(1);
            abort_flag = 1'b0;
            cycles(3);
            m_axis_tready = 1'b1;
            wait_idle("abort", 1);
            check("abort_tlast_count", tlast_seen, 0);
            check("abort_hs_count", hs_count, 5);
        end
`endif

        cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_pulse_sequencer.md
Name: axis_pulse_sequencer

Overview:
- Table-driven sequencer that feeds an AXI4-Stream pulse generator.
- Reads 64-bit pulse words {duration[63:32], reserved[31:16], level[15:0]} from a BRAM table and streams entries 0..last_addr on m_axis.
- Repeats the whole table a configured number of times after a start trigger, then returns to idle.
- Sits between a PS-written BRAM/config register and the pulse generator's slave port.

Parameters:
- BRAM_ADDR_WIDTH, 10, table address width (max 2^BRAM_ADDR_WIDTH entries)
- CNTR_WIDTH, 32, width of the repeat counter and the completed-repeat status

Ports:
- aclk  input  1  clock
- aresetn  input  1  reset, asynchronous, active-low
- cfg_data  input  BRAM_ADDR_WIDTH+CNTR_WIDTH  [BRAM_ADDR_WIDTH-1:0] last_addr (entries-1); [BRAM_ADDR_WIDTH+CNTR_WIDTH-1:BRAM_ADDR_WIDTH] repeats
- trg_flag  input  1  start request, level-sampled each clock
- busy  output  1  high while a sequence is running
- sts_data  output  CNTR_WIDTH  number of completed table passes in the current/last run
- bram_porta_clk  output  1  equals aclk
- bram_porta_rst  output  1  equals ~aresetn
- bram_porta_addr  output  BRAM_ADDR_WIDTH  table read address
- bram_porta_rddata  input  64  table read data, valid 1 cycle after address
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  64  pulse word
- m_axis_tvalid  output  1  word valid
- m_axis_tlast  output  1  high on the final word of the final pass

Behaviour:
- Reset: all registers clear asynchronously.
  - state=IDLE, busy=0, sts_data=0, bram_porta_addr=0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0.
- Clock and reset: single clock aclk; asynchronous active-low reset aresetn.
- Registers: all outputs except bram_porta_clk/bram_porta_rst are registered.
- Internal registers: last_addr_reg, rpt_reg (remaining passes), word_reg.
- IDLE:
  - On trg_flag=1 with repeats!=0: latch last_addr and repeats, set addr=0, sts_data=0, busy=1, go to FETCH.
  - trg_flag with repeats=0 is ignored; busy stays 0.
- FETCH: address is stable; wait one cycle for BRAM latency, then go to LOAD.
- LOAD: capture bram_porta_rddata into word_reg; set m_axis_tvalid=1. Set m_axis_tlast=1 iff addr==last_addr_reg and rpt_reg==1. Go to SEND.
- SEND:
  - Hold tdata, tvalid and tlast stable until m_axis_tready=1.
  - On handshake, drop tvalid and tlast the next cycle.
  - If addr!=last_addr_reg: addr+1, go to FETCH.
  - Else (end of pass): sts_data+1, rpt_reg-1.
    - If rpt_reg==1: busy=0, addr=0, go to IDLE.
    - Otherwise: addr=0, go to FETCH.
- Throughput: max one word per 3 cycles. First tvalid rises 3 cycles after the trigger cycle (FETCH, LOAD, then valid in SEND).
- Config and trigger:
  - cfg_data is sampled only at trigger acceptance; changes while busy have no effect.
  - trg_flag while busy is ignored; no queuing.
- Boundaries:
  - last_addr=0: single-entry table; each pass emits one word.
  - last_addr=2^BRAM_ADDR_WIDTH-1: full table; no address wrap mid-pass.
  - repeats=2^CNTR_WIDTH-1 is valid; rpt_reg decrements without wrap. sts_data wraps naturally only beyond its width, which cannot happen.
- Reset mid-run: immediate return to IDLE with tvalid=0. A word in flight is dropped; downstream sees no handshake for it.
- Table content: m_axis_tdata passes table words unmodified; the sequencer never interprets duration or level.

Optional Feature:
- Macro: AXIS_PULSE_SEQUENCER_ABORT_EN
- When defined:
  - Adds input port abort_flag (1 bit).
  - abort_flag=1 in FETCH or LOAD: go to IDLE next cycle, busy=0, no further words.
  - abort_flag=1 in SEND: the current word completes its handshake, then go to IDLE instead of continuing.
  - sts_data keeps the passes completed so far. tlast is not asserted by an abort.
  - abort_flag in IDLE has no effect.
- When undefined: no abort_flag port; a sequence runs to completion or until reset.

Test Plan:
- Basic run:
  - Stimulus: table {0x00000005_0000_1234, 0x00000003_0000_ABCD}, last_addr=1, repeats=1, trigger, tready=1.
  - Expected: two words in order, tlast on word 2 only, busy falls after word 2, sts_data=1.
- Repeats:
  - Stimulus: last_addr=2, repeats=3, tready=1.
  - Expected: 9 words with address sequence 0,1,2 ×3, sts_data=3 at end, exactly one tlast.
- Backpressure:
  - Stimulus: tready low for 10 cycles during SEND.
  - Expected: tdata/tvalid stable throughout; no word skipped or duplicated.
- Zero and ignored triggers:
  - Stimulus: repeats=0 with trigger, then trigger while busy.
  - Expected: first leaves busy=0 with no tvalid; second has no effect on word count.
- Async reset mid-run:
  - Stimulus: aresetn low during SEND of word 1.
  - Expected: tvalid=0 and busy=0 immediately; after release, a new trigger restarts at addr 0.
- Abort (AXIS_PULSE_SEQUENCER_ABORT_EN):
  - Stimulus: abort in SEND of pass 2 word 0, last_addr=3, repeats=4.
  - Expected: that word handshakes, then IDLE, sts_data=1, no tlast.
